// File: rtl/lomo_pkg.sv
// Shared constants and types for the LOMO link receiver.
// String geometry, FSM state encoding and the header-check word positions.
package lomo_pkg;

    localparam int unsigned WORDS  = 20;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned STR_W  = 6;
    localparam int unsigned FRM_W  = 9;

    // Words carrying the string/frame half-markers.
    localparam int unsigned HALF_A_IDX = 0;
    localparam int unsigned HALF_B_IDX = 10;

    localparam logic [4:0] ZERO_NIB_IDX [4] = '{5'd8, 5'd9, 5'd18, 5'd19};

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } rx_state_e;

    function automatic logic is_zero_nib_idx(input logic [4:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (idx == ZERO_NIB_IDX[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lomo_sync_edge.sv
// Three-flop synchroniser for one asynchronous input.
// With EDGE set the output is a one-cycle rising-edge strobe, otherwise the synchronised level.
module lomo_sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic out_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    always_comb begin
        out_o = EDGE ? (sync_q[1] & ~sync_q[2]) : sync_q[1];
    end

endmodule

// File: rtl/lomo_frame_rx.sv
// LOMO serial string receiver: rebuilds 16-bit words from MK/CLK/DAT,
// checks string header and string/frame sequence, and counts errors.
module lomo_frame_rx #(
    parameter int unsigned WORDS   = lomo_pkg::WORDS,
    parameter int unsigned WORD_W  = lomo_pkg::WORD_W,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MK,
    input  logic                       CLK,
    input  logic                       DAT,
    output logic [WORD_W-1:0]          word_o,
    output logic [$clog2(WORDS)-1:0]   word_idx_o,
    output logic                       word_vld_o,
    output logic                       str_done_o,
    output logic [lomo_pkg::STR_W-1:0] str_num_o,
    output logic [lomo_pkg::FRM_W-1:0] frm_num_o,
    output logic                       err_hdr_o,
    output logic                       err_seq_o,
    output logic                       err_len_o,
    output logic [15:0]                err_cnt_o
);
    import lomo_pkg::*;

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    logic clk_rise, mk_s, dat_s;

    lomo_sync_edge #(.EDGE(1'b1)) u_sync_clk (
        .clk_i(clk), .rst_ni(reset), .async_i(CLK), .out_o(clk_rise)
    );
    lomo_sync_edge #(.EDGE(1'b0)) u_sync_mk (
        .clk_i(clk), .rst_ni(reset), .async_i(MK), .out_o(mk_s)
    );
    lomo_sync_edge #(.EDGE(1'b0)) u_sync_dat (
        .clk_i(clk), .rst_ni(reset), .async_i(DAT), .out_o(dat_s)
    );

    rx_state_e          state_q, state_d;
    logic [WORD_W-1:0]  sh_q, sh_d, word_q, word_d, new_word;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   word_cnt_q, word_cnt_d, idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [WORD_W-1:1]  w0_q, w0_d;
    logic               hdr_bad_q, hdr_bad_d, lock_q, lock_d;
    logic [STR_W-1:0]   str_q, str_d, exp_str;
    logic [FRM_W-1:0]   frm_q, frm_d, exp_frm;
    logic               vld_q, vld_d, done_q, done_d;
    logic               err_hdr_q, err_hdr_d, err_seq_q, err_seq_d, err_len_q, err_len_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic               start, cur_bad, hdr_fail;
    logic [1:0]         err_inc;
    logic [16:0]        err_sum;

    always_comb begin
        new_word = {sh_q[WORD_W-2:0], dat_s};
        // Header rules applicable to the word completing on this edge.
        cur_bad = 1'b0;
        if (word_cnt_q == IDX_W'(HALF_A_IDX) && !new_word[0]) cur_bad = 1'b1;
        if (word_cnt_q == IDX_W'(HALF_B_IDX) &&
            (new_word[0] || new_word[WORD_W-1:1] != w0_q)) cur_bad = 1'b1;
        if (is_zero_nib_idx(word_cnt_q) && new_word[3:0] != 4'h0) cur_bad = 1'b1;
        hdr_fail = hdr_bad_q | cur_bad;
        exp_str  = str_q + STR_W'(1);
        exp_frm  = (str_q == '1) ? frm_q + FRM_W'(1) : frm_q;
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        tmo_d      = tmo_q;
        w0_d       = w0_q;
        hdr_bad_d  = hdr_bad_q;
        word_d     = word_q;
        idx_d      = idx_q;
        str_d      = str_q;
        frm_d      = frm_q;
        lock_d     = lock_q;
        vld_d      = 1'b0;
        done_d     = 1'b0;
        err_hdr_d  = 1'b0;
        err_seq_d  = 1'b0;
        err_len_d  = 1'b0;
        start      = 1'b0;

        case (state_q)
            StIdle: begin
                if (clk_rise && mk_s) start = 1'b1;
            end
            StShift: begin
                if (clk_rise) begin
                    tmo_d = '0;
                    if (mk_s) begin
                        err_len_d = 1'b1;
                        start     = 1'b1;
                    end else if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        sh_d       = new_word;
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + IDX_W'(1);
                        vld_d      = 1'b1;
                        word_d     = new_word;
                        idx_d      = word_cnt_q;
                        hdr_bad_d  = hdr_fail;
                        if (word_cnt_q == IDX_W'(HALF_A_IDX)) w0_d = new_word[WORD_W-1:1];
                        if (word_cnt_q == IDX_W'(WORDS - 1)) begin
                            done_d    = 1'b1;
                            err_hdr_d = hdr_fail;
                            err_seq_d = lock_q &&
                                        (w0_q[STR_W:1] != exp_str ||
                                         w0_q[WORD_W-1:STR_W+1] != exp_frm);
                            str_d     = w0_q[STR_W:1];
                            frm_d     = w0_q[WORD_W-1:STR_W+1];
                            lock_d    = ~hdr_fail;
                            state_d   = StIdle;
                        end
                    end else begin
                        sh_d      = new_word;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_len_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d    = StShift;
            sh_d       = {{(WORD_W - 1){1'b0}}, dat_s};
            bit_cnt_d  = BIT_W'(1);
            word_cnt_d = '0;
            tmo_d      = '0;
            hdr_bad_d  = 1'b0;
        end
        if (err_len_d) lock_d = 1'b0;

        err_inc   = 2'(err_hdr_d) + 2'(err_seq_d) + 2'(err_len_d);
        err_sum   = {1'b0, err_cnt_q} + 17'(err_inc);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            w0_q       <= '0;
            hdr_bad_q  <= 1'b0;
            lock_q     <= 1'b0;
            word_q     <= '0;
            idx_q      <= '0;
            str_q      <= '0;
            frm_q      <= '0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            err_hdr_q  <= 1'b0;
            err_seq_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            tmo_q      <= tmo_d;
            w0_q       <= w0_d;
            hdr_bad_q  <= hdr_bad_d;
            lock_q     <= lock_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            str_q      <= str_d;
            frm_q      <= frm_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            err_hdr_q  <= err_hdr_d;
            err_seq_q  <= err_seq_d;
            err_len_q  <= err_len_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign word_o     = word_q;
    assign word_idx_o = idx_q;
    assign word_vld_o = vld_q;
    assign str_done_o = done_q;
    assign str_num_o  = str_q;
    assign frm_num_o  = frm_q;
    assign err_hdr_o  = err_hdr_q;
    assign err_seq_o  = err_seq_q;
    assign err_len_o  = err_len_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_lomo_frame_rx.sv
// Bench for lomo_frame_rx: string-level model scheduling expected outputs per cycle,
// a per-cycle compare process, and directed scenarios with literal end-point checks.
module tb_lomo_frame_rx;

    localparam int unsigned TIMEOUT = 1024;
    localparam int LAT = 3;  // drive-at-negedge to registered output, in posedges

    logic clk = 1'b0, reset = 1'b1, MK = 1'b0, CLK = 1'b0, DAT = 1'b0;
    logic [15:0] word_o, err_cnt_o;
    logic [4:0]  word_idx_o;
    logic [5:0]  str_num_o;
    logic [8:0]  frm_num_o;
    logic        word_vld_o, str_done_o, err_hdr_o, err_seq_o, err_len_o;

    lomo_frame_rx #(.WORDS(20), .WORD_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .MK(MK), .CLK(CLK), .DAT(DAT),
        .word_o(word_o), .word_idx_o(word_idx_o), .word_vld_o(word_vld_o),
        .str_done_o(str_done_o), .str_num_o(str_num_o), .frm_num_o(frm_num_o),
        .err_hdr_o(err_hdr_o), .err_seq_o(err_seq_o), .err_len_o(err_len_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic vld; logic [15:0] w; logic [4:0] idx;
        logic done; logic [5:0] s; logic [8:0] f;
        logic hdr; logic seq; logic len;
    } ev_t;

    ev_t         evq [int];
    bit          m_open = 0, m_lock = 0;
    int          m_ps = 0, m_pf = 0, m_nb = 0, tmo_at = 0;
    logic [15:0] m_cur;
    logic [15:0] m_words [$];

    logic [15:0] x_word = '0;
    logic [4:0]  x_idx = '0;
    logic [5:0]  x_str = '0;
    logic [8:0]  x_frm = '0;
    int          x_cnt = 0;

    int n_vld = 0, n_done = 0, n_hdr = 0, n_seq = 0, n_len = 0, len_cyc = 0, last_drive = 0;

    function automatic void model_reset();
        evq.delete();
        m_open = 0; m_lock = 0; m_nb = 0;
        m_words.delete();
        x_word = '0; x_idx = '0; x_str = '0; x_frm = '0; x_cnt = 0;
    endfunction

    function automatic void model_edge(input int n, input bit mk, input bit dat);
        ev_t e;
        int  c = n + LAT;
        e = evq.exists(c) ? evq[c] : '0;
        if (mk) begin
            if (m_open) begin e.len = 1'b1; m_lock = 0; end
            m_open = 1; m_words.delete(); m_cur = 16'(dat); m_nb = 1;
        end else if (m_open) begin
            m_cur = {m_cur[14:0], dat};
            m_nb++;
            if (m_nb == 16) begin
                m_words.push_back(m_cur);
                m_nb = 0;
                e.vld = 1'b1; e.w = m_cur; e.idx = 5'(m_words.size() - 1);
                if (m_words.size() == 20) begin
                    bit hdr, seq;
                    int s, f, es, ef;
                    hdr = (m_words[0][0] != 1'b1) || (m_words[10][0] != 1'b0) ||
                          (m_words[10][15:1] != m_words[0][15:1]);
                    foreach (m_words[i])
                        if (i inside {8, 9, 18, 19} && m_words[i][3:0] != 4'h0) hdr = 1;
                    s  = int'(m_words[0][6:1]);
                    f  = int'(m_words[0][15:7]);
                    es = (m_ps + 1) % 64;
                    ef = (m_ps == 63) ? (m_pf + 1) % 512 : m_pf;
                    seq = m_lock && (s != es || f != ef);
                    e.done = 1'b1; e.s = 6'(s); e.f = 9'(f); e.hdr = hdr; e.seq = seq;
                    m_lock = !hdr; m_ps = s; m_pf = f; m_open = 0;
                end
            end
        end
        if (m_open) tmo_at = n + LAT + int'(TIMEOUT);
        evq[c] = e;
    endfunction

    // ---------------- compare ----------------
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            e = evq.exists(cyc) ? evq[cyc] : '0;
            if (evq.exists(cyc)) evq.delete(cyc);
            if (m_open && cyc == tmo_at) begin e.len = 1'b1; m_open = 0; m_lock = 0; end
            if (e.vld) begin x_word = e.w; x_idx = e.idx; end
            if (e.done) begin x_str = e.s; x_frm = e.f; end
            x_cnt = x_cnt + int'(e.hdr) + int'(e.seq) + int'(e.len);
            if (x_cnt > 65535) x_cnt = 65535;
            check("word_vld", 32'(word_vld_o), 32'(e.vld));
            check("str_done", 32'(str_done_o), 32'(e.done));
            check("err_hdr", 32'(err_hdr_o), 32'(e.hdr));
            check("err_seq", 32'(err_seq_o), 32'(e.seq));
            check("err_len", 32'(err_len_o), 32'(e.len));
            check("word_o", 32'(word_o), 32'(x_word));
            check("word_idx", 32'(word_idx_o), 32'(x_idx));
            check("str_num", 32'(str_num_o), 32'(x_str));
            check("frm_num", 32'(frm_num_o), 32'(x_frm));
            check("err_cnt", 32'(err_cnt_o), 32'(x_cnt));
            if (word_vld_o === 1'b1) n_vld++;
            if (str_done_o === 1'b1) n_done++;
            if (err_hdr_o === 1'b1) n_hdr++;
            if (err_seq_o === 1'b1) n_seq++;
            if (err_len_o === 1'b1) begin n_len++; len_cyc = cyc; end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send_bit(input bit mk, input bit dat);
        @(negedge clk);
        MK = mk; DAT = dat; CLK = 1'b1;
        last_drive = cyc;
        model_edge(cyc, mk, dat);
        wait_neg(4);
        CLK = 1'b0; MK = 1'b0;
        wait_neg(3);
    endtask

    task automatic send_string(input int frm, input int str, input bit bad10, input int nbits);
        logic [15:0] ws [20];
        int sent = 0;
        for (int i = 0; i < 20; i++) begin
            ws[i] = 16'((i + 1) * 16'h0B5D);
            if (i inside {8, 9, 18, 19}) ws[i][3:0] = 4'h0;
        end
        ws[0]  = {9'(frm), 6'(str), 1'b1};
        ws[10] = {9'(frm), 6'(str), bad10};
        for (int i = 0; i < 20 && sent < nbits; i++)
            for (int b = 15; b >= 0 && sent < nbits; b--) begin
                send_bit(sent == 0, ws[i][b]);
                sent++;
            end
    endtask

    task automatic settle();
        wait_neg(6);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, 32'(word_o), 0);
        check({tag, "_idx"}, 32'(word_idx_o), 0);
        check({tag, "_flags"}, 32'({word_vld_o, str_done_o, err_hdr_o, err_seq_o, err_len_o}), 0);
        check({tag, "_str"}, 32'(str_num_o), 0);
        check({tag, "_frm"}, 32'(frm_num_o), 0);
        check({tag, "_cnt"}, 32'(err_cnt_o), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst");
        wait_neg(3);
        reset = 1'b1;
    endtask

    initial begin
        int v0, d0;
        #2 reset = 1'b0;
        #1 check_all_zero("por");
        wait_neg(3);
        reset = 1'b1;
        wait_neg(2);

        // Two well-formed strings, then wrap of string number into next frame.
        send_string(5, 62, 0, 320);
        send_string(5, 63, 0, 320);
        settle();
        check("two_str_vld", 32'(n_vld), 40);
        check("two_str_done", 32'(n_done), 2);
        check("two_str_str", 32'(str_num_o), 63);
        check("two_str_frm", 32'(frm_num_o), 5);
        check("two_str_word19", 32'(word_o), 32'(16'((20 * 16'h0B5D)) & 16'hFFF0));
        check("two_str_idx", 32'(word_idx_o), 19);
        send_string(6, 0, 0, 320);
        settle();
        check("wrap_seq", 32'(n_seq), 0);
        check("wrap_cnt", 32'(err_cnt_o), 0);
        check("wrap_frm", 32'(frm_num_o), 6);

        // Frame number fails to advance on string wrap.
        do_reset();
        send_string(5, 63, 0, 320);
        send_string(5, 0, 0, 320);
        settle();
        check("seqbrk_seq", 32'(n_seq), 1);
        check("seqbrk_cnt", 32'(err_cnt_o), 1);

        // Bad half-marker in word 10; following string must not be sequence-checked.
        send_string(5, 1, 1, 320);
        settle();
        check("hdr_hdr", 32'(n_hdr), 1);
        check("hdr_cnt", 32'(err_cnt_o), 2);
        send_string(9, 9, 0, 320);
        settle();
        check("after_hdr_seq", 32'(n_seq), 1);
        check("after_hdr_cnt", 32'(err_cnt_o), 2);

        // Early MK at word 7 bit 3; the restarted string must be received.
        d0 = n_done;
        send_string(9, 10, 0, 7 * 16 + 3);
        send_string(9, 10, 0, 320);
        settle();
        check("early_len", 32'(n_len), 1);
        check("early_done", 32'(n_done - d0), 1);
        check("early_cnt", 32'(err_cnt_o), 3);
        check("early_str", 32'(str_num_o), 10);

        // Serial clock stops after 100 bits.
        v0 = n_vld;
        send_string(1, 1, 0, 100);
        wait_neg(int'(TIMEOUT) + 20);
        #1;
        check("tmo_len", 32'(n_len), 2);
        check("tmo_delay", 32'(len_cyc - last_drive), TIMEOUT + 3);
        check("tmo_vld", 32'(n_vld - v0), 6);
        check("tmo_cnt", 32'(err_cnt_o), 4);
        send_string(2, 2, 0, 320);
        settle();
        check("post_tmo_str", 32'(str_num_o), 2);
        check("post_tmo_cnt", 32'(err_cnt_o), 4);

        // Reset in the middle of a word, then a clean string.
        send_string(3, 3, 0, 40);
        do_reset();
        d0 = n_done;
        send_string(3, 3, 0, 320);
        settle();
        check("post_rst_done", 32'(n_done - d0), 1);
        check("post_rst_str", 32'(str_num_o), 3);
        check("post_rst_frm", 32'(frm_num_o), 3);
        check("post_rst_cnt", 32'(err_cnt_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
